// File: rtl/ifetch.sv
// Instruction fetch unit: one outstanding memory read per instruction, with flush/stall handling.
// Define IFETCH_MISALIGN_CHECK_EN to add misaligned-PC detection and the inst_fault output.
module ifetch (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] pc,
  input  logic        pc_en,
  input  logic        flush,
  input  logic        stall,
  output logic [31:0] inst,
  output logic        inst_ready,
  output logic        mem_ren,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
`ifdef IFETCH_MISALIGN_CHECK_EN
  ,
  output logic        inst_fault
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    DRAIN,
    HOLD,
    DONE
  } state_t;

  state_t state, state_nxt;
  logic   load_addr;
  logic   load_nop;
  logic   capture;
  logic   misaligned;

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic fault_q;
  assign misaligned = (pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    load_addr = 1'b0;
    load_nop  = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (pc_en && !flush) begin
          if (misaligned) begin
            load_nop  = 1'b1;
            state_nxt = DONE;
          end else begin
            load_addr = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        // A flush with no data yet must still wait out the outstanding read.
        if (flush) begin
          state_nxt = mem_ready ? IDLE : DRAIN;
        end else if (mem_ready) begin
          capture   = 1'b1;
          state_nxt = stall ? HOLD : DONE;
        end
      end
      DRAIN: begin
        if (mem_ready) state_nxt = IDLE;
      end
      HOLD: begin
        if (flush)       state_nxt = IDLE;
        else if (!stall) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_ren    = (state == REQ) || (state == DRAIN);
  assign inst_ready = (state == DONE) && !flush;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      inst     <= 32'h0;
      mem_addr <= 32'h0;
    end else begin
      state <= state_nxt;
      if (load_addr) mem_addr <= pc;
      if (capture)       inst <= mem_rdata;
      else if (load_nop) inst <= NOP;
    end
  end

`ifdef IFETCH_MISALIGN_CHECK_EN
  // Flag lasts only for the DONE cycle that follows a misaligned IDLE.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) fault_q <= 1'b0;
    else       fault_q <= load_nop;
  end

  assign inst_fault = fault_q && inst_ready;
`endif

endmodule

// File: tb/tb_ifetch.sv
// Directed self-checking bench for ifetch: zero-wait, wait-state, stall, flush, reset and misalignment cases.
module tb_ifetch;

  logic        clk;
  logic        nrst;
  logic [31:0] pc;
  logic        pc_en;
  logic        flush;
  logic        stall;
  logic [31:0] inst;
  logic        inst_ready;
  logic        mem_ren;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
`ifdef IFETCH_MISALIGN_CHECK_EN
  logic        inst_fault;
`endif

  int numChecks = 0;
  int numFails  = 0;

  ifetch dut (
    .clk       (clk),
    .nrst      (nrst),
    .pc        (pc),
    .pc_en     (pc_en),
    .flush     (flush),
    .stall     (stall),
    .inst      (inst),
    .inst_ready(inst_ready),
    .mem_ren   (mem_ren),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
`ifdef IFETCH_MISALIGN_CHECK_EN
    ,
    .inst_fault(inst_fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] p, input logic pe, input logic fl,
                               input logic st, input logic mr, input logic [31:0] rd);
    pc        = p;
    pc_en     = pe;
    flush     = fl;
    stall     = st;
    mem_ready = mr;
    mem_rdata = rd;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nrst = 1'b0;
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    checkOutput("rst_inst", inst, 32'h0);
    checkOutput("rst_addr", mem_addr, 32'h0);
    checkOutput("rst_ren", {31'b0, mem_ren}, 32'h0);
    checkOutput("rst_ready", {31'b0, inst_ready}, 32'h0);
    stepClock();
    nrst = 1'b1;
    stepClock();
    checkOutput("idle_ren", {31'b0, mem_ren}, 32'h0);

    // Zero-wait fetch
    applyStimulus(32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    stepClock();
    checkOutput("zw_ren", {31'b0, mem_ren}, 32'h1);
    checkOutput("zw_addr", mem_addr, 32'h100);
    checkOutput("zw_noready", {31'b0, inst_ready}, 32'h0);
    applyStimulus(32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0050_0093);
    stepClock();
    checkOutput("zw_ready", {31'b0, inst_ready}, 32'h1);
    checkOutput("zw_inst", inst, 32'h0050_0093);
    checkOutput("zw_ren_off", {31'b0, mem_ren}, 32'h0);
    applyStimulus(32'h104, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    stepClock();
    checkOutput("zw_pulse_end", {31'b0, inst_ready}, 32'h0);
    checkOutput("zw_inst_hold", inst, 32'h0050_0093);

    // Wait states: PC changes while the request is outstanding
    applyStimulus(32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    stepClock();
    checkOutput("ws_ren0", {31'b0, mem_ren}, 32'h1);
    applyStimulus(32'h204, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) begin
      stepClock();
      checkOutput("ws_ren", {31'b0, mem_ren}, 32'h1);
      checkOutput("ws_addr", mem_addr, 32'h200);
      checkOutput("ws_noready", {31'b0, inst_ready}, 32'h0);
    end
    applyStimulus(32'h204, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
    stepClock();
    checkOutput("ws_ready", {31'b0, inst_ready}, 32'h1);
    checkOutput("ws_inst", inst, 32'h1234_5678);
    applyStimulus(32'h204, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    stepClock();
    checkOutput("ws_once", {31'b0, inst_ready}, 32'h0);

    // Stall at capture for three cycles
    applyStimulus(32'h300, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    stepClock();
    applyStimulus(32'h300, 1'b0, 1'b0, 1'b1, 1'b1, 32'hAAAA_5555);
    stepClock();
    checkOutput("st_inst", inst, 32'hAAAA_5555);
    checkOutput("st_noready0", {31'b0, inst_ready}, 32'h0);
    checkOutput("st_ren", {31'b0, mem_ren}, 32'h0);
    applyStimulus(32'h300, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      stepClock();
      checkOutput("st_noready", {31'b0, inst_ready}, 32'h0);
      checkOutput("st_hold", inst, 32'hAAAA_5555);
    end
    stall = 1'b0;
    stepClock();
    checkOutput("st_ready", {31'b0, inst_ready}, 32'h1);
    stepClock();
    checkOutput("st_pulse_end", {31'b0, inst_ready}, 32'h0);

    // Flush two cycles before data arrives
    applyStimulus(32'h400, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    stepClock();
    applyStimulus(32'h500, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    stepClock();
    checkOutput("fl_drain_ren", {31'b0, mem_ren}, 32'h1);
    checkOutput("fl_drain_addr", mem_addr, 32'h400);
    flush = 1'b0;
    stepClock();
    checkOutput("fl_drain_ren2", {31'b0, mem_ren}, 32'h1);
    applyStimulus(32'h500, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    stepClock();
    checkOutput("fl_idle_ren", {31'b0, mem_ren}, 32'h0);
    checkOutput("fl_noready", {31'b0, inst_ready}, 32'h0);
    checkOutput("fl_inst_kept", inst, 32'hAAAA_5555);
    applyStimulus(32'h500, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    stepClock();
    checkOutput("fl_new_addr", mem_addr, 32'h500);
    applyStimulus(32'h500, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0011);
    stepClock();
    checkOutput("fl_new_inst", inst, 32'h0000_0011);
    // Flush during DONE suppresses the pulse
    flush = 1'b1;
    #1;
    checkOutput("fl_done_supp", {31'b0, inst_ready}, 32'h0);
    applyStimulus(32'h500, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    stepClock();

    // Reset while a request is outstanding
    applyStimulus(32'h600, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    stepClock();
    checkOutput("rs_ren_before", {31'b0, mem_ren}, 32'h1);
    applyStimulus(32'h600, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3333_3333);
    #2;
    nrst = 1'b0;
    #1;
    checkOutput("rs_ren", {31'b0, mem_ren}, 32'h0);
    checkOutput("rs_addr", mem_addr, 32'h0);
    checkOutput("rs_inst", inst, 32'h0);
    checkOutput("rs_ready", {31'b0, inst_ready}, 32'h0);
    stepClock();
    nrst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      stepClock();
      checkOutput("rs_post_ready", {31'b0, inst_ready}, 32'h0);
      checkOutput("rs_post_ren", {31'b0, mem_ren}, 32'h0);
    end
    applyStimulus(32'h700, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0022);
    stepClock();
    checkOutput("rs_refetch_addr", mem_addr, 32'h700);
    checkOutput("rs_refetch_noready", {31'b0, inst_ready}, 32'h0);
    pc_en = 1'b0;
    stepClock();
    checkOutput("rs_refetch_ready", {31'b0, inst_ready}, 32'h1);
    checkOutput("rs_refetch_inst", inst, 32'h0000_0022);
    applyStimulus(32'h704, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    stepClock();

    // Misaligned PC
    applyStimulus(32'h102, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    stepClock();
`ifdef IFETCH_MISALIGN_CHECK_EN
    checkOutput("ma_ren", {31'b0, mem_ren}, 32'h0);
    checkOutput("ma_inst", inst, 32'h0000_0013);
    checkOutput("ma_ready", {31'b0, inst_ready}, 32'h1);
    checkOutput("ma_fault", {31'b0, inst_fault}, 32'h1);
    pc_en = 1'b0;
    stepClock();
    checkOutput("ma_fault_end", {31'b0, inst_fault}, 32'h0);
`else
    checkOutput("ma_ren", {31'b0, mem_ren}, 32'h1);
    checkOutput("ma_addr", mem_addr, 32'h102);
    applyStimulus(32'h102, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0044);
    stepClock();
    checkOutput("ma_inst", inst, 32'h0000_0044);
    checkOutput("ma_ready", {31'b0, inst_ready}, 32'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
